// File: rtl/io_port_bank_if.sv
// Datapath side of the I/O port bank: port select, write/read strobes and data.
interface io_port_bank_if #(
    parameter int DW   = 8,
    parameter int ID_W = 2
);
    logic [ID_W-1:0] id;
    logic            wr;
    logic [DW-1:0]   wdata;
    logic            rd;
    logic [DW-1:0]   rdata;

    modport master (output id, wr, wdata, rd, input rdata);
    modport slave  (input id, wr, wdata, rd, output rdata);
endinterface

// File: rtl/io_port_bank.sv
// Parametrised I/O port bank: synchronised inputs, output registers, and (with
// IO_PORT_IRQ_EN defined) per-port change flags with a masked priority interrupt.
module io_port_bank #(
    parameter int NPORTS = 4,
    parameter int DW     = 8,
    parameter int ID_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    io_port_bank_if.slave        bus,
    input  logic [NPORTS*DW-1:0] ein,
    output logic [NPORTS*DW-1:0] sout,
    input  logic [NPORTS-1:0]    imask,
    output logic [NPORTS-1:0]    pend,
    output logic                 irq,
    output logic [ID_W-1:0]      irq_id
);
    logic [NPORTS*DW-1:0] sync1;
    logic [NPORTS*DW-1:0] sync2;
    logic [NPORTS-1:0]    sel;

    // An out-of-range id matches no port, so wr, rd and rdata all fall away.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NPORTS; i++)
            sel[i] = (bus.id == ID_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sout  <= '0;
        end else begin
            sync1 <= ein;
            sync2 <= sync1;
            for (int i = 0; i < NPORTS; i++)
                if (bus.wr && sel[i])
                    sout[i*DW +: DW] <= bus.wdata;
        end
    end

    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NPORTS; i++)
            if (sel[i])
                bus.rdata = sync2[i*DW +: DW];
    end

`ifdef IO_PORT_IRQ_EN
    logic [NPORTS*DW-1:0] prev;
    logic [1:0]           warm;
    logic                 warm_done;
    logic [NPORTS-1:0]    chg;
    logic [NPORTS-1:0]    clr;
    logic [NPORTS-1:0]    masked;
    logic [ID_W-1:0]      low_id;

    assign warm_done = (warm == 2'd3);
    assign clr       = sel & {NPORTS{bus.rd}};
    assign masked    = pend & imask;

    always_comb begin
        chg = '0;
        for (int i = 0; i < NPORTS; i++)
            chg[i] = (sync2[i*DW +: DW] != prev[i*DW +: DW]);
    end

    always_comb begin
        low_id = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (masked[i])
                low_id = ID_W'(i);
    end

    // Set has priority over the acknowledge so a change landing on the ack edge survives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev   <= '0;
            warm   <= 2'd0;
            pend   <= '0;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            prev <= sync2;
            if (!warm_done)
                warm <= warm + 2'd1;
            pend   <= (pend & ~clr) | (chg & {NPORTS{warm_done}});
            irq    <= |masked;
            irq_id <= low_id;
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{bus.rd, imask};
    assign pend      = '0;
    assign irq       = 1'b0;
    assign irq_id    = '0;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// Directed checks of io_port_bank at default parameters and at NPORTS=6, DW=4, ID_W=3.
module tb_io_port_bank;
`ifdef IO_PORT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ein;
    logic [31:0] sout;
    logic [3:0]  imask;
    logic [3:0]  pend;
    logic        irq;
    logic [1:0]  irq_id;

    logic [23:0] ein6;
    logic [23:0] sout6;
    logic [5:0]  imask6;
    logic [5:0]  pend6;
    logic        irq6;
    logic [2:0]  irq_id6;

    int n_chk  = 0;
    int n_fail = 0;

    io_port_bank_if #(.DW(8), .ID_W(2)) bus ();
    io_port_bank_if #(.DW(4), .ID_W(3)) bus6 ();

    io_port_bank #(.NPORTS(4), .DW(8), .ID_W(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .ein(ein), .sout(sout),
        .imask(imask), .pend(pend), .irq(irq), .irq_id(irq_id)
    );

    io_port_bank #(.NPORTS(6), .DW(4), .ID_W(3)) u_dut6 (
        .clk(clk), .reset(reset), .bus(bus6), .ein(ein6), .sout(sout6),
        .imask(imask6), .pend(pend6), .irq(irq6), .irq_id(irq_id6)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.id = '0;  bus.wr = 1'b0;  bus.wdata = '0;  bus.rd = 1'b0;
        bus6.id = '0; bus6.wr = 1'b0; bus6.wdata = '0; bus6.rd = 1'b0;
        ein = 32'hFFFF_FFFF; ein6 = 24'hFF_FFFF;
        imask = 4'b0000; imask6 = 6'h3F;
        reset = 1'b0;

        // reset with all inputs high, then constant inputs through warm-up
        tick(2);
        chk("rst_sout", 64'(sout), 64'h0);
        chk("rst_pend", 64'(pend), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_sout6", 64'(sout6), 64'h0);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("warm_pend", 64'(pend), 64'h0);
            chk("warm_irq", 64'(irq), 64'h0);
        end
        chk("rdata_ff", 64'(bus.rdata), 64'hFF);

        ein = 32'h0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(5);

        // write / read path
        bus.id = 2'd2; bus.wr = 1'b1; bus.wdata = 8'hA5;
        tick(1);
        bus.wr = 1'b0;
        chk("wr_sout", 64'(sout), 64'h00A5_0000);
        ein = 32'h0000_3C00; bus.id = 2'd1;
        tick(1);
        chk("rdata_e0", 64'(bus.rdata), 64'h0);
        tick(1);
        chk("rdata_e1", 64'(bus.rdata), 64'h3C);
        tick(1);
        chk("pend_p1", 64'(pend), IRQ_ON ? 64'h2 : 64'h0);
        tick(1);
        chk("irq_masked", 64'(irq), 64'h0);
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("ack_p1", 64'(pend), 64'h0);

        // single change with irq
        imask = 4'b1111;
        ein = 32'h0100_3C00;
        tick(2);
        chk("chg_e1", 64'(pend), 64'h0);
        tick(1);
        chk("chg_e2", 64'(pend), IRQ_ON ? 64'h8 : 64'h0);
        chk("irq_e2", 64'(irq), 64'h0);
        tick(1);
        chk("irq_e3", 64'(irq), IRQ_ON ? 64'h1 : 64'h0);
        chk("irq_id_e3", 64'(irq_id), IRQ_ON ? 64'h3 : 64'h0);
        bus.id = 2'd3; bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("ack3_pend", 64'(pend), 64'h0);
        chk("ack3_irq", 64'(irq), IRQ_ON ? 64'h1 : 64'h0);
        tick(1);
        chk("ack3_irq_drop", 64'(irq), 64'h0);
        chk("ack3_irq_id", 64'(irq_id), 64'h0);

        // priority and mask
        imask = 4'b1101;
        ein = 32'h0102_3D00;
        tick(3);
        chk("prio_pend", 64'(pend), IRQ_ON ? 64'h6 : 64'h0);
        tick(1);
        chk("prio_irq", 64'(irq), IRQ_ON ? 64'h1 : 64'h0);
        chk("prio_irq_id", 64'(irq_id), IRQ_ON ? 64'h2 : 64'h0);
        bus.id = 2'd2; bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("ack2_pend", 64'(pend), IRQ_ON ? 64'h2 : 64'h0);
        tick(1);
        chk("ack2_irq", 64'(irq), 64'h0);
        chk("ack2_pend1", 64'(pend), IRQ_ON ? 64'h2 : 64'h0);
        bus.id = 2'd1; bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("ack1_pend", 64'(pend), 64'h0);

        // ack on the same edge the change is detected
        ein = 32'h0102_3D55;
        tick(2);
        bus.id = 2'd0; bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("collide_pend", 64'(pend), IRQ_ON ? 64'h1 : 64'h0);
        bus.rd = 1'b1; bus.wr = 1'b1; bus.wdata = 8'h77;
        tick(1);
        bus.rd = 1'b0; bus.wr = 1'b0;
        chk("rdwr_pend", 64'(pend), 64'h0);
        chk("rdwr_sout", 64'(sout), 64'h00A5_0077);
        tick(2);

        // reset in mid-operation overrides wr/rd and restarts warm-up
        ein = 32'h8102_3D55;
        tick(3);
        chk("pre_rst_pend", 64'(pend), IRQ_ON ? 64'h8 : 64'h0);
        reset = 1'b0;
        bus.id = 2'd3; bus.wr = 1'b1; bus.wdata = 8'hEE; bus.rd = 1'b1;
        tick(1);
        chk("mid_rst_sout", 64'(sout), 64'h0);
        chk("mid_rst_pend", 64'(pend), 64'h0);
        chk("mid_rst_irq", 64'(irq), 64'h0);
        chk("mid_rst_rdata", 64'(bus.rdata), 64'h0);
        reset = 1'b1; bus.wr = 1'b0; bus.rd = 1'b0;
        tick(6);
        chk("rewarm_pend", 64'(pend), 64'h0);
        chk("rewarm_irq", 64'(irq), 64'h0);
        chk("rewarm_rdata", 64'(bus.rdata), 64'h81);

        // six-port, 4-bit build
        bus6.id = 3'd7; bus6.wr = 1'b1; bus6.wdata = 4'hF;
        tick(1);
        bus6.wr = 1'b0;
        chk("p6_wr7", 64'(sout6), 64'h0);
        chk("p6_rdata7", 64'(bus6.rdata), 64'h0);
        bus6.id = 3'd5; bus6.wr = 1'b1; bus6.wdata = 4'h9;
        tick(1);
        bus6.wr = 1'b0;
        chk("p6_wr5", 64'(sout6), 64'h90_0000);
        chk("p6_rdata5", 64'(bus6.rdata), 64'hF);
        ein6 = 24'h0F_FFFF;
        tick(3);
        chk("p6_pend", 64'(pend6), IRQ_ON ? 64'h20 : 64'h0);
        bus6.id = 3'd7; bus6.rd = 1'b1;
        tick(1);
        bus6.rd = 1'b0;
        chk("p6_rd7_pend", 64'(pend6), IRQ_ON ? 64'h20 : 64'h0);
        chk("p6_irq", 64'(irq6), IRQ_ON ? 64'h1 : 64'h0);
        chk("p6_irq_id", 64'(irq_id6), IRQ_ON ? 64'h5 : 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised I/O port bank for the single-cycle CPU: NPORTS input ports and NPORTS output registers, each DW bits wide, addressed by the instruction's port id. Generalises the fixed four-port, 8-bit I/O block. Adds three things that block lacks: two-stage input synchronisation, per-port change detection with sticky pending flags, and a masked, prioritised interrupt request. Sits between the datapath (port id, write data, read data) and the board pins.

## Interface
Parameters:
- NPORTS, 4, number of input ports and number of output ports (2..16)
- DW, 8, width of each port in bits
- ID_W, 2, width of the port id; 2**ID_W >= NPORTS is required

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- id  in  ID_W  port selected by the current instruction
- wr  in  1  write strobe: load wdata into output register id
- wdata  in  DW  write data from the datapath
- rd  in  1  read strobe: acknowledges pending flag of port id
- rdata  out  DW  synchronised value of input port id (combinational from registers)
- ein  in  NPORTS*DW  packed raw inputs; port i = ein[i*DW +: DW]
- sout  out  NPORTS*DW  packed output registers; port i = sout[i*DW +: DW]
- imask  in  NPORTS  interrupt enable per port (1 = enabled)
- pend  out  NPORTS  sticky change-pending flags
- irq  out  1  registered interrupt request
- irq_id  out  ID_W  lowest-index pending, enabled port

## Operation
- Reset (reset=0 at an edge) clears: sout, sync1, sync2, prev, pend, irq, irq_id, warm counter. All outputs read 0 on the cycle after the reset edge.
- Input path, per port: sync1 <= ein; sync2 <= sync1; prev <= sync2. rdata = sync2[id].
- Output path: a wr with id < NPORTS sets sout[id] <= wdata. Other ports hold their values.
- Out-of-range id (id >= NPORTS): wr is ignored; rdata = 0; rd clears nothing.
- Warm-up: a 2-bit counter counts 0..3 after reset release and saturates at 3. Change detection is enabled only when the counter equals 3. This suppresses spurious pends from the zeroed pipeline.
- Change detection, per port i: chg[i] = (sync2[i] != prev[i]), any bit. pend[i] <= (pend[i] & ~clr[i]) | (chg[i] & warm_done), where clr[i] = rd & (id == i).
- Simultaneous set and clear on the same port: set wins, so no event is lost.
- A pend flag stays set until acknowledged. Repeated changes before the ack collapse into one flag.
- irq <= |(pend & imask). irq_id <= index of the lowest set bit of (pend & imask), or 0 if none.
- imask only gates irq and irq_id. pend still records changes on masked ports.

## Timing
- ein change set up before edge E0: sync1 at E0, sync2 at E1 (rdata valid after E1), pend at E2, irq/irq_id at E3.
- wr at edge E: sout visible after E (1-cycle latency).
- rd at edge E with no new change: pend[id] reads 0 after E, irq drops after E+1.
- rd and wr to the same id in one cycle: both take effect.
- Reset asserted mid-operation: all state is cleared at that edge regardless of wr/rd; the warm-up restarts.
- The first detectable change is at the 4th edge after reset release.

## Configuration
- IO_PORT_IRQ_EN defined: change detection, pend, irq and irq_id are built as described above.
- IO_PORT_IRQ_EN undefined:
  - prev, the warm-up counter and the pend logic are omitted.
  - pend, irq and irq_id are tied to 0.
  - rd and imask are ignored.
  - The input and output paths are unchanged.

## Test plan
- Reset: hold reset=0 with ein all 0xFF for 2 cycles, then release. Required: sout=0, pend=0, irq=0 throughout; no pend after warm-up while ein is constant.
- Write/read, default parameters: wr id=2 wdata=0xA5 -> sout port2=0xA5, other ports 0. Set ein port1=0x3C, id=1 -> rdata=0x3C two edges later.
- Change + irq (IRQ_EN, imask=4'b1111): ein port3 0x00->0x01 before E0 -> pend=4'b1000 after E2, irq=1 and irq_id=3 after E3. Then rd id=3 -> pend=0, irq=0 one edge later.
- Priority and mask: change ports 1 and 2 in the same cycle with imask=4'b1101 -> pend=4'b0110, irq_id=2. Ack port 2 -> irq=0 while pend[1] stays 1.
- Set/clear collision: rd id=0 on the same edge that chg[0] rises -> pend[0] stays 1.
- Parametrised build: NPORTS=6, DW=4, ID_W=3. wr id=7 is ignored and rdata=0 for id=7. wr id=5 wdata=0x9 -> sout[23:20]=0x9.
